// File: rtl/vram_pixel_writer.sv
// vram_pixel_writer: merges single-pixel framebuffer writes into 32-bit words
// and emits each word as a one-word masked write on a MIG-style user port.
module vram_pixel_writer #(
    parameter logic [29:0] BASE_ADDR    = 30'h0000000,
    parameter int unsigned FLUSH_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        calib_done,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [7:0]  pix_x,
    input  logic [7:0]  pix_y,
    input  logic [7:0]  pix_color,
    input  logic        flush,
    output logic        busy,
    output logic        err,
    output logic        mem_cmd_en,
    output logic [2:0]  mem_cmd_instr,
    output logic [5:0]  mem_cmd_bl,
    output logic [29:0] mem_cmd_byte_addr,
    input  logic        mem_cmd_full,
    output logic        mem_wr_en,
    output logic [3:0]  mem_wr_mask,
    output logic [31:0] mem_wr_data,
    input  logic        mem_wr_full,
    input  logic        mem_wr_underrun,
    input  logic        mem_wr_error
);

    localparam int unsigned ADDR_W  = 30;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LANES   = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned SCREEN_H = 192;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_WR_DATA = 2'd2,
        S_WR_CMD  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [LANES-1:0]    valid_q, valid_d;
    logic [CNT_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic                err_q, err_d;

    logic [ADDR_W-1:0]   pix_addr_c;
    logic                off_screen_c;
    logic                same_word_c;
    logic                trigger_c;
    logic                accept_c;
    logic [LANES-1:0]    lane_mask_c;
    logic [LANES-1:0]    merged_valid_c;

    // Pixel decode: target word, lane, and whether it can merge into the pending word
    always_comb begin
        pix_addr_c     = BASE_ADDR + ADDR_W'({pix_y, pix_x[7:2], 2'b00});
        off_screen_c   = (pix_y >= CNT_W'(SCREEN_H));
        same_word_c    = off_screen_c || (pix_addr_c == addr_q);
        trigger_c      = (valid_q == 4'hF) || flush || (idle_cnt_q == CNT_W'(FLUSH_CYCLES));
        lane_mask_c    = 4'b0001 << pix_x[1:0];
        merged_valid_c = valid_q | lane_mask_c;
        accept_c       = pix_valid && pix_ready;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c && !off_screen_c) begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (trigger_c) begin
                    state_d = S_WR_DATA;
                end else if (pix_valid && calib_done && !same_word_c) begin
                    state_d = S_WR_DATA;
                end else if (accept_c && !off_screen_c && (merged_valid_c == 4'hF)) begin
                    state_d = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (mem_wr_en) begin
                    state_d = S_WR_CMD;
                end
            end
            S_WR_CMD: begin
                if (mem_cmd_en) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and push strobes decoded from state and backpressure
    always_comb begin
        pix_ready  = 1'b0;
        mem_wr_en  = 1'b0;
        mem_cmd_en = 1'b0;
        busy       = 1'b1;
        case (state_q)
            S_IDLE: begin
                pix_ready = calib_done;
                busy      = 1'b0;
            end
            S_ACCUM:   pix_ready  = calib_done && same_word_c && !trigger_c;
            S_WR_DATA: mem_wr_en  = !mem_wr_full;
            S_WR_CMD:  mem_cmd_en = !mem_cmd_full;
            default:   busy       = 1'b1;
        endcase
    end

    // Word register, lane merge, idle counter and sticky error
    always_comb begin
        addr_d     = addr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        idle_cnt_d = idle_cnt_q;
        err_d      = err_q || mem_wr_underrun || mem_wr_error;

        if (accept_c && !off_screen_c) begin
            if (state_q == S_IDLE) begin
                addr_d  = pix_addr_c;
                data_d  = '0;
                valid_d = '0;
            end
            for (int i = 0; i < int'(LANES); i++) begin
                if (lane_mask_c[i]) begin
                    data_d[8*i +: 8] = pix_color;
                end
            end
            valid_d    = valid_d | lane_mask_c;
            idle_cnt_d = '0;
        end else if ((state_q == S_ACCUM) && !accept_c) begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end

        if ((state_q == S_WR_CMD) && mem_cmd_en) begin
            valid_d    = '0;
            idle_cnt_d = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= BASE_ADDR;
            data_q     <= '0;
            valid_q    <= '0;
            idle_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            idle_cnt_q <= idle_cnt_d;
            err_q      <= err_d;
        end
    end

    assign mem_cmd_instr     = 3'b000;
    assign mem_cmd_bl        = 6'd0;
    assign mem_cmd_byte_addr = addr_q;
    assign mem_wr_data       = data_q;
    assign mem_wr_mask       = ~valid_q;
    assign err               = err_q;

endmodule
